// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter for the register file's single write port.
// Grants one of NREQ valid/ready writeback requesters per cycle, then registers the
// winning write for one cycle before it drives the register-file write port.
// Two combinational forwarding taps expose that in-flight write to readers.
// Ports:
//   clk, clr                 clock; asynchronous active-high reset
//   req_valid/ready          per-requester handshake (ready is combinational)
//   req_addr/req_data        packed per-requester address / data
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   fwd_addrN -> fwd_hitN/fwd_dataN  forwarding taps (combinational)
//   conflict_cnt             saturating count of cycles with >= 2 valid requests
module regfile_wb_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic [ADDR_W-1:0]        fwd_addr1,
  input  logic [ADDR_W-1:0]        fwd_addr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [15:0]              conflict_cnt
);

  localparam int unsigned PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PTR_W-1:0]  r_ptr;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic              w_grant_vld;
  logic [PTR_W-1:0]  w_grant_idx;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [NREQ-1:0]   w_ready;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_multi;

  // Round-robin search starting at r_ptr; first valid requester wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_idx       = '0;
    w_ready     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = PTR_W'((32'(r_ptr) + k) % NREQ);
      if (!w_grant_vld && req_valid[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_idx;
      end
    end
    // No transfer may complete while reset is held.
    if (clr) begin
      w_grant_vld = 1'b0;
    end
    if (w_grant_vld) begin
      w_ready[w_grant_idx] = 1'b1;
    end
  end

  // Payload mux driven by the one-hot grant.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_ready[i]) begin
        w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_ptr_nxt = (32'(w_grant_idx) + 32'd1 >= NREQ) ? '0 : w_grant_idx + PTR_W'(1);

  // Two or more bits set <=> clearing the lowest set bit leaves something.
  assign w_multi = |(req_valid & (req_valid - NREQ'(1)));

  // Pointer, staged write and conflict counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ptr          <= '0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_grant_vld) begin
        r_ptr      <= w_ptr_nxt;
        r_rf_we    <= (w_sel_addr != '0);
        r_rf_waddr <= w_sel_addr;
        r_rf_wdata <= w_sel_data;
      end else begin
        r_rf_we    <= 1'b0;
      end
      if (w_multi && (r_conflict_cnt != CNT_MAX)) begin
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      end
    end
  end

  assign req_ready    = w_ready;
  assign rf_we        = r_rf_we;
  assign rf_waddr     = r_rf_waddr;
  assign rf_wdata     = r_rf_wdata;
  assign conflict_cnt = r_conflict_cnt;

  // Forwarding taps see the staged write during the cycle it is being committed.
  assign fwd_hit1  = r_rf_we && (r_rf_waddr == fwd_addr1);
  assign fwd_hit2  = r_rf_we && (r_rf_waddr == fwd_addr2);
  assign fwd_data1 = r_rf_wdata;
  assign fwd_data2 = r_rf_wdata;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural round-robin model.
module tb_regfile_wb_arbiter;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic                   clk = 1'b0;
  logic                   clr;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic [ADDR_W-1:0]      fwd_addr1;
  logic [ADDR_W-1:0]      fwd_addr2;
  logic                   fwd_hit1;
  logic                   fwd_hit2;
  logic [DATA_W-1:0]      fwd_data1;
  logic [DATA_W-1:0]      fwd_data2;
  logic [15:0]            conflict_cnt;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .conflict_cnt(conflict_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state
  int                m_ptr;
  int                m_cnt;
  logic              m_we;
  logic [ADDR_W-1:0] m_waddr;
  logic [DATA_W-1:0] m_wdata;

  logic [NREQ-1:0]        cur_v;
  logic [NREQ*ADDR_W-1:0] cur_a;
  logic [NREQ*DATA_W-1:0] cur_d;
  int                     g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_cnt   = 0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " rf_we"},    64'(rf_we),        64'(m_we));
    chk({tag, " rf_waddr"}, 64'(rf_waddr),     64'(m_waddr));
    chk({tag, " rf_wdata"}, 64'(rf_wdata),     64'(m_wdata));
    chk({tag, " cnt"},      64'(conflict_cnt), 64'(m_cnt));
    chk({tag, " hit1"},     64'(fwd_hit1),     64'(m_we && (m_waddr == fwd_addr1)));
    chk({tag, " hit2"},     64'(fwd_hit2),     64'(m_we && (m_waddr == fwd_addr2)));
    chk({tag, " data1"},    64'(fwd_data1),    64'(m_wdata));
    chk({tag, " data2"},    64'(fwd_data2),    64'(m_wdata));
  endtask

  // One clock cycle: drive, check the grant, clock, update model, check outputs.
  task automatic step(input string tag,
                      input logic [NREQ-1:0]        v,
                      input logic [NREQ*ADDR_W-1:0] a,
                      input logic [NREQ*DATA_W-1:0] d,
                      input logic [ADDR_W-1:0]      fa1,
                      input logic [ADDR_W-1:0]      fa2,
                      output int                    gnt);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    fwd_addr1 = fa1;
    fwd_addr2 = fa2;
    #1;
    gnt = model_grant(v);
    chk({tag, " ready"}, 64'(req_ready), (gnt >= 0) ? (64'd1 << gnt) : 64'd0);
    @(posedge clk);
    if ($countones(v) >= 2 && m_cnt < 65535) m_cnt++;
    if (gnt >= 0) begin
      m_waddr = a[gnt*ADDR_W +: ADDR_W];
      m_wdata = d[gnt*DATA_W +: DATA_W];
      m_we    = (m_waddr != '0);
      m_ptr   = (gnt + 1) % NREQ;
    end else begin
      m_we = 1'b0;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    #1;
    model_reset();
    check_outputs("rst");
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    clr       = 1'b1;
    req_valid = '1;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    fwd_addr1 = '0;
    fwd_addr2 = '0;
    cur_v     = '0;
    cur_a     = '0;
    cur_d     = '0;
    #2;
    model_reset();
    chk("reset ready", 64'(req_ready), 64'd0);
    check_outputs("reset");
    @(posedge clk);
    #1;
    clr = 1'b0;

    // Single requester 1, forwarding tap on the same address
    step("single", 3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 5'd5, 5'd6, g);
    chk("single fwd_hit1", 64'(fwd_hit1), 64'd1);
    chk("single fwd_data1", 64'(fwd_data1), 64'hDEADBEEF);

    // All three requesters continuously valid from a fresh pointer
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step("rr3", 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC3, 32'hB2, 32'hA1}, 5'd2, 5'd3, g);
      chk("rr3 waddr", 64'(rf_waddr), 64'(i % 3 + 1));
      chk("rr3 cnt", 64'(conflict_cnt), 64'(i + 1));
    end

    // Move pointer to 2, then requester 2 writes register 0
    step("pre0", 3'b010, {5'd0, 5'd9, 5'd0}, {32'd0, 32'h99, 32'd0}, 5'd9, 5'd0, g);
    step("addr0", 3'b100, {5'd0, 5'd0, 5'd0}, {32'h1234, 32'd0, 32'd0}, 5'd0, 5'd0, g);
    chk("addr0 rf_we", 64'(rf_we), 64'd0);
    chk("addr0 hit1", 64'(fwd_hit1), 64'd0);
    // Pointer wrapped to 0: requester 0 wins among all three
    step("wrap", 3'b111, {5'd4, 5'd5, 5'd6}, {32'h4, 32'h5, 32'h6}, 5'd6, 5'd4, g);
    chk("wrap waddr", 64'(rf_waddr), 64'd6);

    // Pointer now 1: requesters 0 and 2 valid -> 2 first, then 0
    step("skip1", 3'b101, {5'd12, 5'd0, 5'd10}, {32'h12, 32'h0, 32'h10}, 5'd12, 5'd10, g);
    chk("skip1 waddr", 64'(rf_waddr), 64'd12);
    step("skip2", 3'b101, {5'd12, 5'd0, 5'd10}, {32'h12, 32'h0, 32'h10}, 5'd12, 5'd10, g);
    chk("skip2 waddr", 64'(rf_waddr), 64'd10);

    // Randomized traffic with stable-until-ready requesters
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!cur_v[i] && $urandom_range(0, 1) == 1) begin
          cur_v[i] = 1'b1;
          cur_a[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
          cur_d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
      end
      step("rand", cur_v, cur_a, cur_d,
           ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)), g);
      if (g >= 0) cur_v[g] = 1'b0;
    end

    // Reset in the cycle after a grant to register 7
    step("pre7", 3'b001, {5'd0, 5'd0, 5'd7}, {32'd0, 32'd0, 32'h777}, 5'd7, 5'd7, g);
    chk("pre7 rf_we", 64'(rf_we), 64'd1);
    clr = 1'b1;
    #1;
    model_reset();
    chk("clr ready", 64'(req_ready), 64'd0);
    check_outputs("clr");
    @(posedge clk);
    #1;
    chk("clr held ready", 64'(req_ready), 64'd0);
    check_outputs("clr held");
    clr = 1'b0;
    step("post", 3'b110, {5'd8, 5'd11, 5'd0}, {32'h88, 32'hBB, 32'd0}, 5'd11, 5'd7, g);
    chk("post waddr", 64'(rf_waddr), 64'd11);
    chk("post hit2", 64'(fwd_hit2), 64'd0);

    // Counter saturation
    for (int c = 0; c < 70000; c++) begin
      step("sat", 3'b011, {5'd0, 5'd14, 5'd13}, {32'd0, 32'hE, 32'hD}, 5'd13, 5'd14, g);
    end
    chk("sat final", 64'(conflict_cnt), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
